// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmit sequencer.
package morse_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMark,
    StSpace,
    StCharGap,
    StWordGap
  } state_e;

  localparam logic [5:0] CODE_SPACE     = 6'd36;
  localparam logic [5:0] CODE_MAX_VALID = 6'd36;

  localparam int unsigned DOT_U        = 1;
  localparam int unsigned DASH_U       = 3;
  localparam int unsigned ELEM_GAP_U   = 1;
  localparam int unsigned CHAR_GAP_U   = 3;
  localparam int unsigned WORD_EXTRA_U = 4;

  // Phase lengths are held as "units remaining minus one" so 1..4 fits in two bits.
  function automatic logic [1:0] load_units(input int unsigned units);
    return 2'(units - 1);
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational character-code to Morse pattern lookup.
// pat is MSB-first over the first len bits, 1 = dash; space returns len 0.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] char_code,
  output logic [2:0] len,
  output logic [4:0] pat,
  output logic       valid
);

  always_comb begin
    {len, pat} = 8'b0;
    valid      = (char_code <= CODE_MAX_VALID);
    case (char_code)
      6'd0:  {len, pat} = {3'd2, 5'b01000}; // A
      6'd1:  {len, pat} = {3'd4, 5'b10000}; // B
      6'd2:  {len, pat} = {3'd4, 5'b10100}; // C
      6'd3:  {len, pat} = {3'd3, 5'b10000}; // D
      6'd4:  {len, pat} = {3'd1, 5'b00000}; // E
      6'd5:  {len, pat} = {3'd4, 5'b00100}; // F
      6'd6:  {len, pat} = {3'd3, 5'b11000}; // G
      6'd7:  {len, pat} = {3'd4, 5'b00000}; // H
      6'd8:  {len, pat} = {3'd2, 5'b00000}; // I
      6'd9:  {len, pat} = {3'd4, 5'b01110}; // J
      6'd10: {len, pat} = {3'd3, 5'b10100}; // K
      6'd11: {len, pat} = {3'd4, 5'b01000}; // L
      6'd12: {len, pat} = {3'd2, 5'b11000}; // M
      6'd13: {len, pat} = {3'd2, 5'b10000}; // N
      6'd14: {len, pat} = {3'd3, 5'b11100}; // O
      6'd15: {len, pat} = {3'd4, 5'b01100}; // P
      6'd16: {len, pat} = {3'd4, 5'b11010}; // Q
      6'd17: {len, pat} = {3'd3, 5'b01000}; // R
      6'd18: {len, pat} = {3'd3, 5'b00000}; // S
      6'd19: {len, pat} = {3'd1, 5'b10000}; // T
      6'd20: {len, pat} = {3'd3, 5'b00100}; // U
      6'd21: {len, pat} = {3'd4, 5'b00010}; // V
      6'd22: {len, pat} = {3'd3, 5'b01100}; // W
      6'd23: {len, pat} = {3'd4, 5'b10010}; // X
      6'd24: {len, pat} = {3'd4, 5'b10110}; // Y
      6'd25: {len, pat} = {3'd4, 5'b11000}; // Z
      6'd26: {len, pat} = {3'd5, 5'b11111}; // 0
      6'd27: {len, pat} = {3'd5, 5'b01111}; // 1
      6'd28: {len, pat} = {3'd5, 5'b00111}; // 2
      6'd29: {len, pat} = {3'd5, 5'b00011}; // 3
      6'd30: {len, pat} = {3'd5, 5'b00001}; // 4
      6'd31: {len, pat} = {3'd5, 5'b00000}; // 5
      6'd32: {len, pat} = {3'd5, 5'b10000}; // 6
      6'd33: {len, pat} = {3'd5, 5'b11000}; // 7
      6'd34: {len, pat} = {3'd5, 5'b11100}; // 8
      6'd35: {len, pat} = {3'd5, 5'b11110}; // 9
      default: {len, pat} = 8'b0;
    endcase
  end

endmodule

// File: rtl/morse_tx_sequencer.sv
// Morse transmit sequencer: accepts one character per handshake and keys morse_out with
// standard unit timing. Optional sidetone generator enabled by `define SIDETONE_EN.
module morse_tx_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES      = 1000000,
  parameter int unsigned CNT_W            = 20,
  parameter int unsigned TONE_HALF_CYCLES = 8333
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [5:0] char_code,
  output logic       char_ready,
  output logic       morse_out,
  output logic       busy,
  output logic       err,
  output logic       tone_out
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] unit_cnt_q, unit_cnt_d;
  logic [1:0]       units_q, units_d;
  logic [2:0]       len_q, len_d;
  logic [4:0]       pat_q, pat_d;
  logic [2:0]       idx_q, idx_d;
  logic             err_d;
  logic             morse_out_q, busy_q, char_ready_q, err_q;

  logic [2:0] rom_len;
  logic [4:0] rom_pat;
  logic       rom_valid;
  logic       transfer;
  logic       tick;

  morse_rom u_rom (
    .char_code (char_code),
    .len       (rom_len),
    .pat       (rom_pat),
    .valid     (rom_valid)
  );

  assign transfer = char_valid && char_ready_q;
  assign tick     = (state_q != StIdle) && (unit_cnt_q == CNT_W'(UNIT_CYCLES - 1));

  // Phases always end on a tick, so the counter is already 0 at each phase start.
  always_comb begin
    unit_cnt_d = unit_cnt_q + 1'b1;
    if (state_q == StIdle || tick) begin
      unit_cnt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    units_d = units_q;
    len_d   = len_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          if (char_code == CODE_SPACE) begin
            state_d = StWordGap;
            units_d = load_units(WORD_EXTRA_U);
          end else if (rom_valid) begin
            state_d = StMark;
            len_d   = rom_len;
            pat_d   = rom_pat;
            idx_d   = 3'd0;
            units_d = rom_pat[4] ? load_units(DASH_U) : load_units(DOT_U);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StMark: begin
        if (tick) begin
          if (units_q != 2'd0) begin
            units_d = units_q - 2'd1;
          end else if (idx_q == 3'(len_q - 3'd1)) begin
            state_d = StCharGap;
            units_d = load_units(CHAR_GAP_U);
          end else begin
            state_d = StSpace;
            units_d = load_units(ELEM_GAP_U);
          end
        end
      end
      StSpace: begin
        if (tick) begin
          if (units_q != 2'd0) begin
            units_d = units_q - 2'd1;
          end else begin
            state_d = StMark;
            idx_d   = idx_q + 3'd1;
            pat_d   = {pat_q[3:0], 1'b0};
            units_d = pat_q[3] ? load_units(DASH_U) : load_units(DOT_U);
          end
        end
      end
      StCharGap, StWordGap: begin
        if (tick) begin
          if (units_q != 2'd0) begin
            units_d = units_q - 2'd1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      unit_cnt_q   <= '0;
      units_q      <= '0;
      len_q        <= '0;
      pat_q        <= '0;
      idx_q        <= '0;
      morse_out_q  <= 1'b0;
      busy_q       <= 1'b0;
      char_ready_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      unit_cnt_q   <= unit_cnt_d;
      units_q      <= units_d;
      len_q        <= len_d;
      pat_q        <= pat_d;
      idx_q        <= idx_d;
      morse_out_q  <= (state_d == StMark);
      busy_q       <= (state_d != StIdle);
      char_ready_q <= (state_d == StIdle);
      err_q        <= err_d;
    end
  end

  assign morse_out  = morse_out_q;
  assign busy       = busy_q;
  assign char_ready = char_ready_q;
  assign err        = err_q;

`ifdef SIDETONE_EN
  localparam int unsigned ToneW = (TONE_HALF_CYCLES > 1) ? $clog2(TONE_HALF_CYCLES) : 1;

  logic [ToneW-1:0] tone_cnt_q;
  logic             tone_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (!morse_out_q) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (tone_cnt_q == ToneW'(TONE_HALF_CYCLES - 1)) begin
      tone_cnt_q <= '0;
      tone_q     <= ~tone_q;
    end else begin
      tone_cnt_q <= tone_cnt_q + 1'b1;
    end
  end

  // Mask so the tone stops on the same cycle the key line drops.
  assign tone_out = tone_q & morse_out_q;
`else
  logic unused_tone_cfg;
  assign unused_tone_cfg = (TONE_HALF_CYCLES == 0);
  assign tone_out        = 1'b0;
`endif

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Self-checking bench for morse_tx_sequencer with UNIT_CYCLES = 4.
module tb_morse_tx_sequencer;

  localparam int unsigned U    = 4;
  localparam int unsigned TONE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       char_valid;
  logic [5:0] char_code;
  logic       char_ready, morse_out, busy, err, tone_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0] code;
    string      pat;     // '.' and '-' elements, " " for word space, "" for invalid
    bit         is_err;
  } vec_t;

  vec_t vecs[10];
  bit   exp_q[$];
  bit   tone_exp_q[$];

  morse_tx_sequencer #(
    .UNIT_CYCLES      (U),
    .CNT_W            (20),
    .TONE_HALF_CYCLES (TONE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_ready (char_ready),
    .morse_out  (morse_out),
    .busy       (busy),
    .err        (err),
    .tone_out   (tone_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_run(input bit level, input int n);
    for (int j = 0; j < n; j++) begin
      exp_q.push_back(level);
`ifdef SIDETONE_EN
      tone_exp_q.push_back(level ? bit'((j / TONE) % 2) : 1'b0);
`else
      tone_exp_q.push_back(1'b0);
`endif
    end
  endfunction

  // Expected key waveform, one entry per cycle after the transfer.
  function automatic void build_wave(input string p);
    exp_q.delete();
    tone_exp_q.delete();
    if (p == " ") begin
      push_run(1'b0, 4 * U);
    end else begin
      for (int i = 0; i < p.len(); i++) begin
        push_run(1'b1, (p.getc(i) == 8'h2D) ? 3 * U : U);
        push_run(1'b0, (i == p.len() - 1) ? 3 * U : U);
      end
    end
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (char_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready_timeout"}, char_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int bad = 0;
    int tbad = 0;
    wait_ready(name);
    @(negedge clk);
    char_valid = 1'b1;
    char_code  = v.code;
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    char_code  = 6'($urandom);
    if (v.is_err) begin
      check({name, "_err_pulse"}, err, 1'b1);
      check({name, "_err_ready"}, char_ready, 1'b1);
      check({name, "_err_morse"}, {busy, morse_out}, 2'b00);
      @(negedge clk);
      check({name, "_err_clear"}, err, 1'b0);
    end else begin
      build_wave(v.pat);
      for (int k = 0; k < exp_q.size(); k++) begin
        if (morse_out !== exp_q[k] || busy !== 1'b1 || char_ready !== 1'b0 || err !== 1'b0)
          bad++;
        if (tone_out !== tone_exp_q[k]) tbad++;
        if (k < exp_q.size() - 1) @(negedge clk);
      end
      check({name, "_wave_bad_cycles"}, bad, 0);
      check({name, "_tone_bad_cycles"}, tbad, 0);
      @(negedge clk);
      check({name, "_done"}, {char_ready, busy, morse_out}, 3'b100);
    end
  endtask

  initial begin
    vecs[0] = '{code: 6'd4,  pat: ".",     is_err: 1'b0};
    vecs[1] = '{code: 6'd0,  pat: ".-",    is_err: 1'b0};
    vecs[2] = '{code: 6'd26, pat: "-----", is_err: 1'b0};
    vecs[3] = '{code: 6'd19, pat: "-",     is_err: 1'b0};
    vecs[4] = '{code: 6'd16, pat: "--.-",  is_err: 1'b0};
    vecs[5] = '{code: 6'd31, pat: ".....", is_err: 1'b0};
    vecs[6] = '{code: 6'd36, pat: " ",     is_err: 1'b0};
    vecs[7] = '{code: 6'd40, pat: "",      is_err: 1'b1};
    vecs[8] = '{code: 6'd63, pat: "",      is_err: 1'b1};
    vecs[9] = '{code: 6'd24, pat: "-.--",  is_err: 1'b0};

    rst        = 1'b1;
    char_valid = 1'b0;
    char_code  = 6'd0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {char_ready, morse_out, busy, err, tone_out}, 5'b10000);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {char_ready, morse_out, busy, err}, 4'b1000);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d_code%0d", i, vecs[i].code));
    end

    // Space with char_valid held high, then 'E' taken on the first ready cycle.
    begin
      int bad = 0;
      wait_ready("hold");
      @(negedge clk);
      char_valid = 1'b1;
      char_code  = 6'd36;
      @(posedge clk);
      @(negedge clk);
      char_code = 6'd4;
      for (int k = 0; k < 4 * U; k++) begin
        if (morse_out !== 1'b0 || busy !== 1'b1 || char_ready !== 1'b0) bad++;
        if (k < 4 * U - 1) @(negedge clk);
      end
      check("hold_space_wave", bad, 0);
      @(negedge clk);
      check("hold_ready_cycle", {char_ready, morse_out}, 2'b10);
      @(negedge clk);
      char_valid = 1'b0;
      check("hold_e_started", {char_ready, morse_out, busy}, 3'b011);
      wait_ready("hold_e_done");
    end

    // Reset six cycles into a dash.
    @(negedge clk);
    char_valid = 1'b1;
    char_code  = 6'd19;
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("dash_mid_mark", morse_out, 1'b1);
    #2 rst = 1'b1;
    #1 check("async_reset", {morse_out, busy, tone_out, char_ready}, 4'b0001);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_idle", {char_ready, busy, morse_out}, 3'b100);
    run_vec(vecs[0], "recover_e");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
